// File: rtl/mips_pkg.sv
// Shared constants for the MIPS data-memory stage: MMIO window base and
// register byte offsets, also used by firmware-facing testbenches.
package mips_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [7:0] MMIO_OUT    = 8'h00;
    localparam logic [7:0] MMIO_CYCLES = 8'h04;
    localparam logic [7:0] MMIO_STATUS = 8'h08;

    // Word slot of an MMIO byte offset, as decoded from addr[7:2].
    function automatic logic [5:0] mmio_slot(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 data RAM: combinational read, synchronous write with enable.
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage with optional MMIO window (OUT, CYCLES, STATUS).
// Define DMEM_MMIO_EN to enable the window; otherwise all accesses hit RAM.
module dmem_mmio
    import mips_pkg::*;
#(
    parameter int          DEPTH   = 64,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic [31:0] ioOut,
    output logic        errFlag
);

    localparam int AW = $clog2(DEPTH);

    logic        aligned;
    logic        is_io;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // Only addr[31] decodes the window; IO_BASE and the middle address bits are informational.
    logic unused_bits;
    assign unused_bits = ^{addr, IO_BASE};

    assign aligned = (addr[1:0] == 2'b00);
    // Gating with reset keeps a store on the reset edge out of the non-reset RAM.
    assign ram_we  = memWrite & aligned & ~is_io & reset;

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (addr[AW+1:2]),
        .wdata (writeData),
        .rdata (ram_rdata)
    );

`ifdef DMEM_MMIO_EN
    logic [5:0]  off;
    logic        io_we;
    logic [31:0] cycles;
    logic [31:0] io_q;
    logic        err_q;
    logic [31:0] io_rdata;

    assign is_io = addr[31];
    assign off   = addr[7:2];
    assign io_we = memWrite & aligned & is_io;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
            io_q   <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (io_we && off == mmio_slot(MMIO_OUT)) io_q <= writeData;
        end
    end

    // Set wins over clear; a misaligned STATUS write never reaches the clear anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                                   err_q <= 1'b0;
        else if (memWrite && !aligned)                                err_q <= 1'b1;
        else if (io_we && off == mmio_slot(MMIO_STATUS) && writeData[0]) err_q <= 1'b0;
    end

    always_comb begin
        io_rdata = '0;
        case (off)
            mmio_slot(MMIO_OUT):    io_rdata = io_q;
            mmio_slot(MMIO_CYCLES): io_rdata = cycles;
            mmio_slot(MMIO_STATUS): io_rdata = {31'b0, err_q};
            default:                io_rdata = '0;
        endcase
    end

    assign readData = is_io ? io_rdata : ram_rdata;
    assign ioOut    = io_q;
    assign errFlag  = err_q;
`else
    logic err_q;

    assign is_io = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    err_q <= 1'b0;
        else if (memWrite && !aligned) err_q <= 1'b1;
    end

    assign readData = ram_rdata;
    assign ioOut    = '0;
    assign errFlag  = err_q;
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: directed scenarios then random traffic,
// checked against an array-based reference model.
module tb_dmem_mmio;

    localparam int DEPTH = 64;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [31:0] ioOut;
    logic        errFlag;

    dmem_mmio #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .memWrite  (memWrite),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .ioOut     (ioOut),
        .errFlag   (errFlag)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [31:0] m_ram [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_io;
    logic [31:0] m_cyc;
    bit          m_err;

    typedef struct {
        logic [31:0] rd;
        bit          rd_chk;
        logic [31:0] io;
        bit          err;
        int          id;
        logic [31:0] a;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic bit m_is_io(logic [31:0] a);
        return MMIO_EN && a[31];
    endfunction

    function automatic int m_idx(logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic int m_off(logic [31:0] a);
        return int'((a % 256) / 4);
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        if (m_is_io(a)) begin
            case (m_off(a))
                0:       return m_io;
                1:       return m_cyc;
                2:       return {31'b0, m_err};
                default: return 32'h0;
            endcase
        end
        return m_ram[m_idx(a)];
    endfunction

    function automatic bit m_readable(logic [31:0] a);
        return m_is_io(a) || m_known[m_idx(a)];
    endfunction

    task automatic m_edge(bit we, logic [31:0] a, logic [31:0] d);
        if (we && (a % 4) != 0) begin
            m_err = 1'b1;
        end else if (we) begin
            if (m_is_io(a)) begin
                if (m_off(a) == 0) m_io = d;
                else if (m_off(a) == 2 && d[0]) m_err = 1'b0;
            end else begin
                m_ram[m_idx(a)]   = d;
                m_known[m_idx(a)] = 1'b1;
            end
        end
        m_cyc = m_cyc + 1;
    endtask

    task automatic push_exp(logic [31:0] a, int id);
        exp_t e;
        e.rd = m_read(a); e.rd_chk = m_readable(a);
        e.io = m_io; e.err = m_err; e.id = id; e.a = a;
        q.push_back(e);
    endtask

    // Called just after a rising edge; applies one cycle of stimulus.
    task automatic step(bit we, logic [31:0] a, logic [31:0] d, int id);
        reset = 1'b1; memWrite = we; addr = a; writeData = d;
        push_exp(a, id);
        m_edge(we, a, d);
        @(posedge clk); #1;
    endtask

    // One cycle with reset held low; any store presented is expected to be lost.
    task automatic reset_step(bit we, logic [31:0] a, logic [31:0] d, int id);
        reset = 1'b0; memWrite = we; addr = a; writeData = d;
        m_io = '0; m_cyc = '0; m_err = 1'b0;
        push_exp(a, id);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.rd_chk) begin
                vectors++;
                if (readData !== e.rd) begin
                    miscompares++;
                    $display("FAIL readData id=%0d addr=%h got=%h exp=%h", e.id, e.a, readData, e.rd);
                end
            end
            vectors++;
            if (ioOut !== e.io) begin
                miscompares++;
                $display("FAIL ioOut id=%0d got=%h exp=%h", e.id, ioOut, e.io);
            end
            vectors++;
            if (errFlag !== e.err) begin
                miscompares++;
                $display("FAIL errFlag id=%0d got=%b exp=%b", e.id, errFlag, e.err);
            end
        end
    end

    initial begin
        logic [31:0] r, a, d;
        int sel;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        m_io = '0; m_cyc = '0; m_err = 1'b0;
        reset = 1'b0; memWrite = 1'b0; addr = '0; writeData = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_step(1'b0, 32'h8000_0004, 32'h0, 1);

        // counter: the 11th read after release sees 10
        for (int i = 0; i < 11; i++) step(1'b0, 32'h8000_0004, 32'h0, 10 + i);
        step(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 30);
        step(1'b0, 32'h0000_0004, 32'h0, 31);
        step(1'b1, 32'h0000_0100, 32'hCAFE_BABE, 32);
        step(1'b0, 32'h0000_0000, 32'h0, 33);
        step(1'b1, 32'h0000_0006, 32'h1234_5678, 34);
        step(1'b0, 32'h0000_0004, 32'h0, 35);
        step(1'b1, 32'h8000_0008, 32'h0000_0001, 36);
        step(1'b0, 32'h8000_0008, 32'h0, 37);
        step(1'b1, 32'h8000_0000, 32'h0000_00A5, 38);
        step(1'b0, 32'h8000_0000, 32'h0, 39);
        step(1'b1, 32'h8000_0004, 32'h0000_0055, 40);
        step(1'b0, 32'h8000_0004, 32'h0, 41);
        step(1'b0, 32'h0000_0004, 32'h0, 42);
        step(1'b0, 32'h8000_0010, 32'h0, 43);

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            d = $urandom();
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1: a = {1'b0, r[30:2], 2'b00};
                2:    a = {r[31:2], 2'b00} | 32'(1 + (r[1:0] % 3));
                3:    a = {1'b1, r[30:8], 6'(r[1:0]), 2'b00};
                4:    a = {1'b1, r[30:8], r[7:2], 2'b00};
                default: a = {1'b0, 23'(r[30:8]), 6'(r[7:2]), 2'b00};
            endcase
            if (i == 200) begin
                reset_step(1'b1, 32'h0000_0000, 32'h7777_7777, 500);
                reset_step(1'b0, 32'h8000_0004, 32'h0, 501);
                step(1'b0, 32'h0000_0000, 32'h0, 502);
                step(1'b0, 32'h0000_0004, 32'h0, 503);
            end
            step(($urandom_range(0, 1) == 1), a, d, 1000 + i);
        end

        memWrite = 1'b0;
        repeat (2) @(posedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
